// File: rtl/inst_fetch.sv
// inst_fetch: PC owner issuing single-outstanding imem reads into a 2-entry (pc, inst) FIFO with redirect flush.
module inst_fetch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    input  logic              id_ready_i
);
    localparam int EW = ADDR_W + DATA_W;
    typedef enum logic {S_REQ, S_WAIT} state_e;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic discard_q, discard_d;
    logic [1:0] count_q, count_d;
    logic [EW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic hs, push, pop, resp;
    assign imem_req_o = !rst && state_q == S_REQ && count_q < 2'd2;
    assign imem_addr_o = imem_req_o ? pc_q : '0;
    assign hs = imem_req_o && imem_gnt_i;
    assign resp = state_q == S_WAIT && imem_rvalid_i;
    assign push = resp && !discard_q && !redirect_i;
    assign if_valid_o = !rst && count_q != 2'd0;
    assign pop = if_valid_o && id_ready_i && !redirect_i;
    assign {if_pc_o, if_inst_o} = if_valid_o ? e0_q : '0;
    always_comb begin
        state_d = hs ? S_WAIT : resp ? S_REQ : state_q;
        req_pc_d = hs ? pc_q : req_pc_q;
        pc_d = redirect_i ? redirect_pc_i : hs ? pc_q + ADDR_W'(PC_INC) : pc_q;
        // A redirect with a request still in flight must swallow that response.
        discard_d = (redirect_i && (hs || (state_q == S_WAIT && !imem_rvalid_i))) ? 1'b1 :
                    resp ? 1'b0 : discard_q;
        e0_d = pop ? e1_q : e0_q;
        e1_d = e1_q;
        if (push) begin
            if ((count_q - {1'b0, pop}) == 2'd0) e0_d = {req_pc_q, imem_rdata_i};
            else e1_d = {req_pc_q, imem_rdata_i};
        end
        count_d = redirect_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q <= RESET_PC;
            req_pc_q <= '0;
            discard_q <= 1'b0;
            count_q <= 2'd0;
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
            discard_q <= discard_d;
            count_q <= count_d;
            e0_q <= e0_d;
            e1_q <= e1_d;
        end
    end
    assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd2));
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table plus scripted corner sequences for inst_fetch.
module tb_inst_fetch;
    logic clk = 1'b0, rst = 1'b1;
    logic gnt = 1'b0, rvalid = 1'b0, redirect = 1'b0, ready = 1'b1;
    logic [31:0] rdata = '0, redirect_pc = '0;
    logic req, valid, req2, valid2;
    logic [31:0] addr, pc, inst, addr2, pc2, inst2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .if_valid_o(valid), .if_pc_o(pc), .if_inst_o(inst),
        .id_ready_i(ready)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .if_valid_o(valid2), .if_pc_o(pc2), .if_inst_o(inst2),
        .id_ready_i(ready)
    );

    typedef struct {
        logic rst, gnt, rv;
        logic [31:0] rd;
        logic rdy, ereq;
        logic [31:0] eaddr;
        logic evalid;
        logic [31:0] epc, einst;
    } vec_t;
    vec_t tv[12];

    function automatic logic [31:0] iof(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdr, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        gnt = g; rvalid = rv; rdata = rd; redirect = rdr; redirect_pc = rp; ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; gnt = 0; rvalid = 0; rdata = '0; redirect = 0; redirect_pc = '0; ready = 1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1, 0, 0, 0,          1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[1]  = '{1, 0, 0, 0,          1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[2]  = '{1, 0, 0, 0,          1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[3]  = '{0, 1, 0, 0,          1, 1, 32'h0,  0, 32'h0, 32'h0};
        tv[4]  = '{0, 1, 1, iof(32'h0), 1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[5]  = '{0, 1, 0, 0,          1, 1, 32'h4,  1, 32'h0, iof(32'h0)};
        tv[6]  = '{0, 1, 1, iof(32'h4), 1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[7]  = '{0, 1, 0, 0,          1, 1, 32'h8,  1, 32'h4, iof(32'h4)};
        tv[8]  = '{0, 1, 1, iof(32'h8), 1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[9]  = '{0, 1, 0, 0,          1, 1, 32'hC,  1, 32'h8, iof(32'h8)};
        tv[10] = '{0, 1, 1, iof(32'hC), 1, 0, 32'h0,  0, 32'h0, 32'h0};
        tv[11] = '{0, 0, 0, 0,          1, 1, 32'h10, 1, 32'hC, iof(32'hC)};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst = tv[i].rst; gnt = tv[i].gnt; rvalid = tv[i].rv; rdata = tv[i].rd;
            redirect = 0; redirect_pc = '0; ready = tv[i].rdy;
            #1;
            chk($sformatf("vec%0d req", i), 32'(req), 32'(tv[i].ereq));
            chk($sformatf("vec%0d addr", i), addr, tv[i].eaddr);
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tv[i].evalid));
            chk($sformatf("vec%0d pc", i), pc, tv[i].epc);
            chk($sformatf("vec%0d inst", i), inst, tv[i].einst);
        end

        // grant withheld: request and address must hold
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 1);
            chk("nogrant req", 32'(req), 32'd1);
            chk("nogrant addr", addr, 32'h10);
        end

        // decode stall fills FIFO, then drains in order
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        chk("stall addr0", addr, 32'h0);
        step(0, 1, iof(32'h0), 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("stall req1", 32'(req), 32'd1);
        chk("stall addr4", addr, 32'h4);
        step(0, 1, iof(32'h4), 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk("stall full req", 32'(req), 32'd0);
            chk("stall head valid", 32'(valid), 32'd1);
            chk("stall head pc", pc, 32'h0);
            chk("stall head inst", inst, iof(32'h0));
        end
        step(1, 0, 0, 0, 0, 1);
        chk("drain pc0", pc, 32'h0);
        chk("drain req while full", 32'(req), 32'd0);
        step(1, 0, 0, 0, 0, 1);
        chk("drain pc4", pc, 32'h4);
        chk("drain inst4", inst, iof(32'h4));
        chk("drain addr8", addr, 32'h8);
        step(0, 1, iof(32'h8), 0, 0, 1);
        chk("drain gap", 32'(valid), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("drain pc8", pc, 32'h8);
        chk("drain inst8", inst, iof(32'h8));

        // redirect while waiting, then second redirect on the stale response
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 32'h300, 1);
        chk("redir wait req", 32'(req), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("redir hold req", 32'(req), 32'd0);
        step(0, 1, iof(32'h0), 1, 32'h100, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("redir stale dropped", 32'(valid), 32'd0);
        chk("redir addr", addr, 32'h100);
        step(0, 1, iof(32'h100), 0, 0, 1);
        chk("redir gap", 32'(valid), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("redir pc", pc, 32'h100);
        chk("redir inst", inst, iof(32'h100));

        // redirect coinciding with rvalid and pop
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, iof(32'h0), 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("coin head pc", pc, 32'h0);
        step(0, 1, iof(32'h4), 1, 32'h200, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("coin flushed", 32'(valid), 32'd0);
        chk("coin req", 32'(req), 32'd1);
        chk("coin addr", addr, 32'h200);
        step(0, 1, iof(32'h200), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("coin pc", pc, 32'h200);
        chk("coin inst", inst, iof(32'h200));

        // PC wrap from the top of the address space
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        chk("wrap addr top", addr2, 32'hFFFF_FFFC);
        step(0, 1, iof(32'hFFFF_FFFC), 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("wrap addr zero", addr2, 32'h0);
        chk("wrap req", 32'(req2), 32'd1);
        chk("wrap pc top", pc2, 32'hFFFF_FFFC);
        step(0, 1, iof(32'h0), 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("wrap pc zero", pc2, 32'h0);
        chk("wrap inst zero", inst2, iof(32'h0));
        chk("wrap valid", 32'(valid2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
